// File: rtl/ls_pkg.sv
// Shared encodings for the load/store unit: op codes, FSM states, default address width.
package ls_pkg;

    localparam int LS_ADDR_BITS = 12;

    typedef enum logic [2:0] {
        OP_LB  = 3'd0,
        OP_LBU = 3'd1,
        OP_LH  = 3'd2,
        OP_LHU = 3'd3,
        OP_LW  = 3'd4,
        OP_SB  = 3'd5,
        OP_SH  = 3'd6,
        OP_SW  = 3'd7
    } ls_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } ls_state_t;

    function automatic logic op_is_load(input ls_op_t op);
        return op <= OP_LW;
    endfunction

    function automatic logic op_misaligned(input ls_op_t op, input logic [1:0] offset);
        logic mis;
        mis = 1'b0;
        case (op)
            OP_LH, OP_LHU, OP_SH: mis = offset[0];
            OP_LW, OP_SW:         mis = (offset != 2'b00);
            default:              mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/ls_lane_align.sv
// Big-endian lane select/extend for loads and lane merge for byte/halfword stores.
// Purely combinational; no state, no handshake.
module ls_lane_align
    import ls_pkg::*;
(
    input  ls_op_t      op,
    input  logic [1:0]  offset,
    input  logic [31:0] rd_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] store_word
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rd_word[31:24];
        case (offset)
            2'd0: byte_v = rd_word[31:24];
            2'd1: byte_v = rd_word[23:16];
            2'd2: byte_v = rd_word[15:8];
            2'd3: byte_v = rd_word[7:0];
            default: byte_v = rd_word[31:24];
        endcase
        half_v = offset[1] ? rd_word[15:0] : rd_word[31:16];

        load_val = rd_word;
        case (op)
            OP_LB:   load_val = {{24{byte_v[7]}}, byte_v};
            OP_LBU:  load_val = {24'd0, byte_v};
            OP_LH:   load_val = {{16{half_v[15]}}, half_v};
            OP_LHU:  load_val = {16'd0, half_v};
            default: load_val = rd_word;
        endcase

        // Stores of less than a word keep the untouched lanes of the word just read.
        store_word = wdata;
        case (op)
            OP_SB: begin
                store_word = rd_word;
                case (offset)
                    2'd0: store_word[31:24] = wdata[7:0];
                    2'd1: store_word[23:16] = wdata[7:0];
                    2'd2: store_word[15:8]  = wdata[7:0];
                    2'd3: store_word[7:0]   = wdata[7:0];
                    default: store_word = rd_word;
                endcase
            end
            OP_SH: begin
                store_word = rd_word;
                if (offset[1]) store_word[15:0]  = wdata[15:0];
                else           store_word[31:16] = wdata[15:0];
            end
            default: store_word = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: loads and SW take 2 cycles after acceptance, SB/SH (read-modify-write) 3, misaligned 1.
// No backpressure: ls_req is sampled only in IDLE; requests while busy are dropped, not queued.
module load_store_unit
    import ls_pkg::*;
#(
    parameter int ADDR_BITS = LS_ADDR_BITS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ls_req,
    input  logic [2:0]  ls_op,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_busy,
    output logic        ls_done,
    output logic [31:0] ls_rdata,
    output logic        ls_misalign,
    output logic        dm_cs,
    output logic        dm_rd,
    output logic        dm_wr,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_din,
    input  logic [31:0] dm_dout
);

    ls_state_t              state, state_nx;
    ls_op_t                 op_q;
    logic [ADDR_BITS-1:0]   addr_q;
    logic [31:0]            wdata_q;
    logic                   mis_q;

    ls_op_t                 op_in;
    logic                   mis_in;
    logic [31:0]            word_addr;
    logic [31:0]            load_val;
    logic [31:0]            store_word;
    logic                   unused_addr_hi;

    assign op_in          = ls_op_t'(ls_op);
    assign mis_in         = op_misaligned(op_in, ls_addr[1:0]);
    assign word_addr      = 32'({addr_q[ADDR_BITS-1:2], 2'b00});
    assign unused_addr_hi = ^ls_addr[31:ADDR_BITS];

    ls_lane_align u_lane_align (
        .op         (op_q),
        .offset     (addr_q[1:0]),
        .rd_word    (dm_dout),
        .wdata      (wdata_q),
        .load_val   (load_val),
        .store_word (store_word)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        ls_busy     = (state != ST_IDLE);
        ls_done     = 1'b0;
        ls_misalign = 1'b0;
        dm_cs       = 1'b0;
        dm_rd       = 1'b0;
        dm_wr       = 1'b0;
        dm_addr     = 32'd0;
        dm_din      = 32'd0;
        case (state)
            ST_IDLE: begin
                if (ls_req) begin
                    if (mis_in)                 state_nx = ST_DONE;
                    else if (op_in == OP_SW)    state_nx = ST_WR;
                    else                        state_nx = ST_RD;
                end
            end
            ST_RD: begin
                dm_cs    = 1'b1;
                dm_rd    = 1'b1;
                dm_addr  = word_addr;
                state_nx = op_is_load(op_q) ? ST_DONE : ST_WR;
            end
            ST_WR: begin
                dm_cs    = 1'b1;
                dm_wr    = 1'b1;
                dm_addr  = word_addr;
                dm_din   = wdata_q;
                state_nx = ST_DONE;
            end
            ST_DONE: begin
                ls_done     = 1'b1;
                ls_misalign = mis_q;
                state_nx    = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // wdata_q doubles as the merged write word once the RMW read has returned.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q     <= OP_LB;
            addr_q   <= '0;
            wdata_q  <= 32'd0;
            mis_q    <= 1'b0;
            ls_rdata <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ls_req) begin
                        op_q    <= op_in;
                        addr_q  <= ls_addr[ADDR_BITS-1:0];
                        wdata_q <= ls_wdata;
                        mis_q   <= mis_in;
                        if (mis_in && op_is_load(op_in)) ls_rdata <= 32'd0;
                    end
                end
                ST_RD: begin
                    if (op_is_load(op_q)) ls_rdata <= load_val;
                    else                  wdata_q  <= store_word;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 12, meaning the data-memory byte-address width (4096 bytes).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port ls_req, input, 1, CPU access request, sampled only in IDLE.
REQ-005 SHALL have port ls_op, input, 3, operation: LB=0, LBU=1, LH=2, LHU=3, LW=4, SB=5, SH=6, SW=7.
REQ-006 SHALL have port ls_addr, input, 32, byte address.
REQ-007 SHALL have port ls_wdata, input, 32, store data, right-justified for SB/SH.
REQ-008 SHALL have port ls_busy, output, 1, high in every state except IDLE.
REQ-009 SHALL have port ls_done, output, 1, one-cycle completion pulse.
REQ-010 SHALL have port ls_rdata, output, 32, load result, extended per op.
REQ-011 SHALL have port ls_misalign, output, 1, valid with ls_done; high means the access was rejected.
REQ-012 SHALL have ports dm_cs, dm_rd and dm_wr, outputs, 1 each, data-memory chip select, read enable and write enable.
REQ-013 SHALL have port dm_addr, output, 32, word-aligned memory address.
REQ-014 SHALL have port dm_din, output, 32, write word to memory.
REQ-015 SHALL have port dm_dout, input, 32, combinational big-endian read word from memory.

Function
REQ-016 SHALL implement the Moore FSM IDLE, RD, WR, DONE; memory controls decode from the state register only.
REQ-017 SHALL accept ls_req only in IDLE; requests in other states are ignored and not queued.
REQ-018 SHALL latch ls_op, ls_addr and ls_wdata on acceptance and hold them until DONE.
REQ-019 SHALL drive dm_addr as {zeros, addr[ADDR_BITS-1:2], 2'b00} in RD and WR; bits at or above ADDR_BITS are ignored.
REQ-020 SHALL assert dm_cs and dm_rd in RD only, dm_cs and dm_wr in WR only, and all three low elsewhere.
REQ-021 SHALL handle loads IDLE->RD->DONE, capturing dm_dout at the end of RD; ls_done rises 2 cycles after acceptance.
REQ-022 SHALL handle SW IDLE->WR->DONE with dm_din equal to ls_wdata; ls_done rises 2 cycles after acceptance.
REQ-023 SHALL handle SB/SH as read-modify-write IDLE->RD->WR->DONE, replacing only the addressed lane(s) of the read word; ls_done rises 3 cycles after acceptance.
REQ-024 SHALL use big-endian lanes: byte offset 0 is bits [31:24] and offset 3 is bits [7:0]; halfword offset 0 is [31:16] and offset 2 is [15:0].
REQ-025 SHALL sign-extend LB/LH, zero-extend LBU/LHU, and pass LW unchanged.
REQ-026 SHALL treat LH/LHU/SH with addr[0]=1, and LW/SW with addr[1:0]!=0, as misaligned: IDLE->DONE, no memory access, ls_misalign=1, ls_rdata=0.
REQ-027 SHALL pulse ls_done for exactly one cycle in DONE, then return to IDLE; a new request is accepted the following cycle.
REQ-028 SHALL hold ls_rdata until the next completing load; stores and misaligned stores do not alter it.

Reset
REQ-029 SHALL on reset go to IDLE and clear ls_busy, ls_done, ls_misalign, ls_rdata, dm_cs, dm_rd, dm_wr, dm_addr and dm_din to 0, independent of clk.
REQ-030 SHALL, on reset asserted mid-operation, abort with no memory write at any later edge and no ls_done pulse.

Structure
REQ-031 SHALL place op encodings, FSM state encoding and default ADDR_BITS in shared package ls_pkg.
REQ-032 SHALL factor lane extraction, extension and store merge into one combinational sub-module ls_lane_align.

Verification
REQ-033 SHALL cover: mem[0x100..0x103]=80 12 34 56, LB at 0x100 -> ls_rdata=FFFFFF80, ls_done 2 cycles after acceptance.
REQ-034 SHALL cover: same memory, LHU at 0x102 -> ls_rdata=00003456; LH at 0x100 -> FFFF8012.
REQ-035 SHALL cover: mem[0x200]=AABBCCDD, SB 0x201 with wdata=00000011 -> word AA11CCDD, exactly one dm_wr cycle, ls_done at cycle 3.
REQ-036 SHALL cover: SW at 0x206 -> ls_misalign=1, ls_done at cycle 1, dm_cs never high, memory unchanged.
REQ-037 SHALL cover: reset asserted during RD of an SH -> no dm_wr, all outputs 0, and the next LW returns the original word.
REQ-038 SHALL cover: ls_req held high through a busy LW -> second access starts only in the IDLE cycle after ls_done.
